// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronises btn_in and toggles btn_level only after a stable window.
// Optional rejected-glitch counter enabled by defining BUTTON_DEBOUNCER_GLITCH_CNT_EN.
module button_debouncer #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 16,
   parameter bit          RESET_LEVEL   = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       busy
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_ARMING = 1'b1
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_in;
   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   level_q;

   // NOTE: every clocked block uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign sync_in = sync_q[SYNC_STAGES-1];

   // Any return to the current level while arming restarts qualification from scratch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         level_q <= RESET_LEVEL;
      end else begin
         unique case (state_q)
            ST_STABLE: begin
               if (sync_in != level_q) begin
                  state_q <= ST_ARMING;
                  cnt_q   <= CNT_W'(1);
               end else begin
                  cnt_q   <= '0;
               end
            end
            ST_ARMING: begin
               if (sync_in == level_q) begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  level_q <= ~level_q;
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign btn_level = level_q;
   assign busy      = (state_q == ST_ARMING);

`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
   logic [7:0] gcnt_q;

   // Saturating count of qualifications abandoned without a toggle.
   always_ff @(posedge clk) begin
      if (reset) begin
         gcnt_q <= '0;
      end else if (state_q == ST_ARMING && sync_in == level_q && gcnt_q != 8'hFF) begin
         gcnt_q <= gcnt_q + 8'd1;
      end
   end

   assign glitch_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (SYNC_STAGES=2, STABLE_CYCLES=4, both reset levels).
// Stimulus pushes expected level/busy transitions; a negedge monitor pops and compares them.
module tb_button_debouncer;

   localparam int LAT = 6;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst0, rst1, btn0, btn1;
   logic lvl0, lvl1, busy0, busy1;
   logic lvl0_p, lvl1_p, busy0_p, busy1_p;
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
   logic [7:0] gc0, gc1;
`endif

   ev_t ql0[$], qb0[$], ql1[$], qb1[$];
   ev_t e;
   int  checks = 0;
   int  errors = 0;
   int  exp_gc = 0;
   bit  mon_en = 1'b0;

   button_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) dut0 (
      .clk       (clk),
      .reset     (rst0),
      .btn_in    (btn0),
      .btn_level (lvl0),
      .busy      (busy0)
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
      ,
      .glitch_cnt(gc0)
`endif
   );

   button_debouncer #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b1)) dut1 (
      .clk       (clk),
      .reset     (rst1),
      .btn_in    (btn1),
      .btn_level (lvl1),
      .busy      (busy1)
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
      ,
      .glitch_cnt(gc1)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int ch, input int c, input int v);
      ev_t t;
      t.cyc = c;
      t.val = v;
      case (ch)
         0: ql0.push_back(t);
         1: qb0.push_back(t);
         2: ql1.push_back(t);
         default: qb1.push_back(t);
      endcase
   endtask

   // Clean level change on dut0 or dut1, held long enough to qualify.
   task automatic press(input int dut, input logic v);
      int c;
      c = cyc;
      push(dut * 2,     c + 1 + LAT, int'(v));
      push(dut * 2 + 1, c + 3,       1);
      push(dut * 2 + 1, c + 1 + LAT, 0);
      if (dut == 0) btn0 = v;
      else          btn1 = v;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (lvl0 !== lvl0_p) begin
            if (ql0.size() == 0) check("lvl0_unexpected", cyc, -1);
            else begin
               e = ql0.pop_front();
               check("lvl0_cyc", cyc, e.cyc);
               check("lvl0_val", int'(lvl0), e.val);
            end
         end
         if (busy0 !== busy0_p) begin
            if (qb0.size() == 0) check("busy0_unexpected", cyc, -1);
            else begin
               e = qb0.pop_front();
               check("busy0_cyc", cyc, e.cyc);
               check("busy0_val", int'(busy0), e.val);
            end
         end
         if (lvl1 !== lvl1_p) begin
            if (ql1.size() == 0) check("lvl1_unexpected", cyc, -1);
            else begin
               e = ql1.pop_front();
               check("lvl1_cyc", cyc, e.cyc);
               check("lvl1_val", int'(lvl1), e.val);
            end
         end
         if (busy1 !== busy1_p) begin
            if (qb1.size() == 0) check("busy1_unexpected", cyc, -1);
            else begin
               e = qb1.pop_front();
               check("busy1_cyc", cyc, e.cyc);
               check("busy1_val", int'(busy1), e.val);
            end
         end
      end
      lvl0_p  <= lvl0;
      busy0_p <= busy0;
      lvl1_p  <= lvl1;
      busy1_p <= busy1;
   end

   initial begin
      int c;
      int pat[6];
      pat = '{1, 0, 1, 1, 0, 1};
      rst0 = 1'b1;
      rst1 = 1'b1;
      btn0 = 1'b0;
      btn1 = 1'b1;
      wait_neg(3);
      check("rst0_level", int'(lvl0), 0);
      check("rst0_busy",  int'(busy0), 0);
      check("rst1_level", int'(lvl1), 1);
      check("rst1_busy",  int'(busy1), 0);
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
      check("rst0_gcnt", int'(gc0), 0);
`endif
      rst0   = 1'b0;
      rst1   = 1'b0;
      mon_en = 1'b1;
      wait_neg(4);

      // Clean press and release
      press(0, 1'b1);
      wait_neg(12);
      press(0, 1'b0);
      wait_neg(12);

      // Three-cycle glitch: busy for three cycles, no toggle
      c = cyc;
      push(1, c + 3, 1);
      push(1, c + 6, 0);
      btn0 = 1'b1;
      wait_neg(3);
      btn0 = 1'b0;
      wait_neg(10);
      exp_gc = 1;
      check("glitch_level", int'(lvl0), 0);
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
      check("glitch_gcnt", int'(gc0), exp_gc);
`endif

      // Bounce train 1,0,1,1,0,1 then held high
      c = cyc;
      push(1, c + 3, 1);
      push(1, c + 4, 0);
      push(1, c + 5, 1);
      push(1, c + 7, 0);
      push(1, c + 8, 1);
      push(1, c + 12, 0);
      push(0, c + 12, 1);
      for (int i = 0; i < 6; i++) begin
         btn0 = logic'(pat[i]);
         wait_neg(1);
      end
      wait_neg(12);
      exp_gc = 3;
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
      check("bounce_gcnt", int'(gc0), exp_gc);
`endif
      press(0, 1'b0);
      wait_neg(12);

      // Reset at edge 4 of a press, then full requalification
      c = cyc;
      push(1, c + 3, 1);
      push(1, c + 5, 0);
      btn0 = 1'b1;
      wait_neg(4);
      rst0 = 1'b1;
      wait_neg(1);
      check("midrst_level", int'(lvl0), 0);
      check("midrst_busy",  int'(busy0), 0);
      wait_neg(1);
      c = cyc;
      push(0, c + 1 + LAT, 1);
      push(1, c + 3, 1);
      push(1, c + 1 + LAT, 0);
      rst0 = 1'b0;
      wait_neg(12);
      exp_gc = 0;
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
      check("midrst_gcnt", int'(gc0), exp_gc);
`endif
      press(0, 1'b0);
      wait_neg(12);

      // 300 isolated single-cycle glitches
      for (int g = 1; g <= 300; g++) begin
         push(1, cyc + 3, 1);
         push(1, cyc + 4, 0);
         btn0 = 1'b1;
         wait_neg(1);
         btn0 = 1'b0;
         wait_neg(3);
         if (exp_gc < 255) exp_gc++;
`ifdef BUTTON_DEBOUNCER_GLITCH_CNT_EN
         if (g == 100 || g == 255 || g == 300) check("sat_gcnt", int'(gc0), exp_gc);
`endif
      end
      wait_neg(4);
      check("sat_level", int'(lvl0), 0);

      // Active-low button: RESET_LEVEL=1 instance
      press(1, 1'b0);
      wait_neg(10);
      press(1, 1'b1);
      wait_neg(12);

      wait_neg(2);
      check("ql0_left", ql0.size(), 0);
      check("qb0_left", qb0.size(), 0);
      check("ql1_left", ql1.size(), 0);
      check("qb1_left", qb1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for the edge-detector stage.
- Takes a raw asynchronous push-button or switch input and synchronises it into clk.
- Rejects bounce and glitches shorter than a programmable stability window.
- Presents a clean, registered level (btn_level) that the edge-detector stage samples to generate its rising/falling pulses.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- STABLE_CYCLES, 16, consecutive synchronised cycles the input must differ from btn_level before btn_level toggles; legal range 1..2^20.
- RESET_LEVEL, 0, value loaded into synchroniser flops and btn_level on reset (0 = released, 1 = pressed for active-low buttons).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_in  input  1  raw asynchronous button/switch level
- btn_level  output  1  debounced, registered level
- busy  output  1  high while a candidate change is being qualified (state ARMING)
- glitch_cnt  output  8  rejected-glitch counter (present only with GLITCH_CNT_EN)

Behaviour:
- Clock and reset: clk drives everything. reset is synchronous, active-high, and takes priority over all other logic.
- Reset values:
  - sync chain = RESET_LEVEL on every stage
  - btn_level = RESET_LEVEL
  - state = STABLE
  - counter = 0
  - busy = 0
  - glitch_cnt = 0
- Synchroniser: btn_in passes through SYNC_STAGES flops; the last stage is sync_in. No other logic touches btn_in.
- Counter width: CNT_W = $clog2(STABLE_CYCLES+1), unsigned.
- FSM, two states:
  - STABLE:
    - sync_in == btn_level -> stay; counter held at 0.
    - sync_in != btn_level -> ARMING; counter <= 1.
  - ARMING:
    - sync_in == btn_level -> STABLE; counter <= 0. Counts as one rejected glitch.
    - else if counter == STABLE_CYCLES -> btn_level <= ~btn_level; STABLE; counter <= 0.
    - else -> counter <= counter + 1.
- Latency: take edge 0 as the first rising edge that samples btn_in at its new value and holds it steady. btn_level changes on edge SYNC_STAGES + STABLE_CYCLES. Example with defaults: 18 edges.
- busy = (state == ARMING). busy is decoded from the registered state and is glitch-free.
- Any single-cycle return of sync_in to btn_level during ARMING fully restarts qualification. There is no partial credit.
- btn_level changes by at most one toggle per qualification, and is never unchanged for fewer than 1 cycle between toggles.
- Reset asserted mid-ARMING abandons qualification: btn_level returns to RESET_LEVEL regardless of its prior value.
- After reset deasserts while btn_in differs from RESET_LEVEL, the normal qualification path applies. There is no fast path.
- Counter must never wrap. Its maximum reached value is STABLE_CYCLES.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt port exists: 8-bit saturating counter.
  - Increments by 1 on every ARMING -> STABLE transition without a toggle.
  - Holds at 255 once reached.
  - Cleared only by reset.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour and timing are identical.

Test Plan (SYNC_STAGES=2, STABLE_CYCLES=4, RESET_LEVEL=0 unless noted):
- Clean press: btn_in 0->1 and held.
  - busy rises on edge 2 and falls on edge 6.
  - btn_level rises exactly on edge 6, not earlier.
  - Release 1->0 mirrors this: btn_level falls 6 edges after the first sampling edge.
- Short glitch: btn_in high for 3 cycles, then low.
  - btn_level stays 0; busy pulses high for 3 cycles.
  - glitch_cnt = 1 (if enabled).
- Bounce train: 1,0,1,1,0,1 per cycle, then held 1.
  - btn_level rises exactly 6 edges after the final 0->1 sample.
  - glitch_cnt = 2 (if enabled).
- Reset mid-qualification: press held; assert reset at edge 4 (counter=2).
  - btn_level = 0, busy = 0 on next edge.
  - After reset release with btn_in still 1, btn_level rises only after a full new qualification.
- RESET_LEVEL=1: after reset btn_level = 1.
  - btn_in low for 10 cycles -> btn_level falls on edge 6.
  - btn_in returns high -> btn_level rises 6 edges later.
- Saturation (macro defined): 300 isolated 1-cycle glitches -> glitch_cnt reads 255 and stays 255; btn_level remains 0 throughout.
